mag_share_arb: RTL and testbench

- Arbitrates two complex-sample requesters onto one shared approximate-magnitude unit (|re|+|im|/2 style, fixed latency).
- Requesters: the auto-correlation packet detector (port 0) and the cross-correlation timing sync (port 1).
- Drives the unit's enable/real/imag inputs and tags each issued sample in a shift pipeline. Returns each result to its owner and flags protocol mismatches.
- Sits in the RX front end between the correlators and a single magnitude instance, saving one magnitude datapath.

---
 rtl/mag_share_arb_pkg.sv | 25 ++
 rtl/mag_share_arb_rr.sv | 58 +++++
 rtl/mag_share_arb.sv | 131 +++++++++++++
 tb/tb_mag_share_arb.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mag_share_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mag_share_arb_pkg
// Brief    : Shared types and constants for the magnitude-unit share arbiter.
// Revision : 1.0
// ============================================================================
package mag_share_arb_pkg;

  localparam logic c_PORT_AUTO  = 1'b0;
  localparam logic c_PORT_XCORR = 1'b1;

  localparam int c_MAG_LAT_MIN = 1;
  localparam int c_MAG_LAT_MAX = 4;
  localparam int c_BURST_MIN   = 1;
  localparam int c_BURST_MAX   = 15;
  localparam int c_BURST_CNT_W = 4;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/mag_share_arb_rr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mag_share_rr
// Brief    : Two-port burst-limited arbiter with owner/burst-count tracking.
// Revision : 1.0
// ============================================================================
module mag_share_rr
  import mag_share_arb_pkg::*;
#(
  parameter int BURST = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req0_val,
  input  logic req1_val,
  output logic gnt0,
  output logic gnt1,
  output logic gnt_id,
  output logic gnt_any
);

  localparam logic [c_BURST_CNT_W-1:0] c_BURST = c_BURST_CNT_W'(BURST);

  logic                     r_owner;
  logic [c_BURST_CNT_W-1:0] r_burst_cnt;

  always_comb begin
    gnt_any = req0_val | req1_val;
    gnt_id  = c_PORT_AUTO;
    // Under contention the owner keeps the unit until its burst allowance runs out.
    if (req0_val && req1_val) begin
      gnt_id = (r_burst_cnt < c_BURST) ? r_owner : ~r_owner;
    end else if (req1_val) begin
      gnt_id = c_PORT_XCORR;
    end
    gnt0 = gnt_any & (gnt_id == c_PORT_AUTO);
    gnt1 = gnt_any & (gnt_id == c_PORT_XCORR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner     <= c_PORT_AUTO;
      r_burst_cnt <= '0;
    end else if (gnt_any) begin
      if (gnt_id == r_owner) begin
        if (r_burst_cnt < c_BURST) begin
          r_burst_cnt <= r_burst_cnt + 1'b1;
        end
      end else begin
        r_owner     <= gnt_id;
        r_burst_cnt <= c_BURST_CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mag_share_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mag_share_arb
// Brief    : Shares one fixed-latency magnitude unit between two correlators.
// Revision : 1.0
// ============================================================================
module mag_share_arb
  import mag_share_arb_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int MAG_LAT = 1,
  parameter int BURST   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_val,
  input  logic [WIDTH-1:0] req0_real,
  input  logic [WIDTH-1:0] req0_imag,
  output logic             req0_rdy,
  input  logic             req1_val,
  input  logic [WIDTH-1:0] req1_real,
  input  logic [WIDTH-1:0] req1_imag,
  output logic             req1_rdy,
  output logic             mu_ena,
  output logic [WIDTH-1:0] mu_real,
  output logic [WIDTH-1:0] mu_imag,
  input  logic [WIDTH:0]   mu_mag,
  input  logic             mu_val,
  output logic             res0_val,
  output logic [WIDTH:0]   res0_mag,
  output logic             res1_val,
  output logic [WIDTH:0]   res1_mag,
  output logic             err
);

  if (MAG_LAT < c_MAG_LAT_MIN || MAG_LAT > c_MAG_LAT_MAX) begin : g_bad_mag_lat
    $error("mag_share_arb: MAG_LAT out of range");
  end
  if (BURST < c_BURST_MIN || BURST > c_BURST_MAX) begin : g_bad_burst
    $error("mag_share_arb: BURST out of range");
  end

  logic w_gnt0;
  logic w_gnt1;
  logic w_gnt_id;
  logic w_gnt_any;
  logic r_issue_id;
  tag_t r_tag [MAG_LAT];
  tag_t w_tag_last;
  logic w_hit;

  mag_share_rr #(
    .BURST (BURST)
  ) u_rr (
    .clk      (clk),
    .rst      (rst),
    .req0_val (req0_val),
    .req1_val (req1_val),
    .gnt0     (w_gnt0),
    .gnt1     (w_gnt1),
    .gnt_id   (w_gnt_id),
    .gnt_any  (w_gnt_any)
  );

  assign req0_rdy = w_gnt0;
  assign req1_rdy = w_gnt1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mu_ena     <= 1'b0;
      mu_real    <= '0;
      mu_imag    <= '0;
      r_issue_id <= c_PORT_AUTO;
    end else begin
      mu_ena <= w_gnt_any;
      if (w_gnt_any) begin
        r_issue_id <= w_gnt_id;
        mu_real    <= (w_gnt_id == c_PORT_XCORR) ? req1_real : req0_real;
        mu_imag    <= (w_gnt_id == c_PORT_XCORR) ? req1_imag : req0_imag;
      end
    end
  end

  // Stage 0 captures the tag alongside the presented mu_ena; the last stage lines up with mu_val.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag[0] <= '0;
    end else begin
      r_tag[0] <= '{valid: mu_ena, id: r_issue_id};
    end
  end

  for (genvar gi = 1; gi < MAG_LAT; gi++) begin : g_tag_pipe
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_tag[gi] <= '0;
      end else begin
        r_tag[gi] <= r_tag[gi-1];
      end
    end
  end

  assign w_tag_last = r_tag[MAG_LAT-1];
  assign w_hit      = mu_val & w_tag_last.valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res0_val <= 1'b0;
      res1_val <= 1'b0;
      res0_mag <= '0;
      res1_mag <= '0;
      err      <= 1'b0;
    end else begin
      res0_val <= w_hit & (w_tag_last.id == c_PORT_AUTO);
      res1_val <= w_hit & (w_tag_last.id == c_PORT_XCORR);
      if (w_hit && (w_tag_last.id == c_PORT_AUTO)) begin
        res0_mag <= mu_mag;
      end
      if (w_hit && (w_tag_last.id == c_PORT_XCORR)) begin
        res1_mag <= mu_mag;
      end
      // Orphan result or missing result: either way the pairing is broken.
      if (mu_val != w_tag_last.valid) begin
        err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mag_share_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mag_share_arb
// Brief    : Scoreboard bench; one instance at MAG_LAT=1, one at MAG_LAT=3.
// Revision : 1.0
// ============================================================================
module tb_mag_share_arb;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [W:0]  mag;
    logic [31:0] due;
  } exp_t;

  exp_t sb_a0[$];
  exp_t sb_a1[$];
  exp_t sb_b0[$];
  exp_t sb_b1[$];

  function automatic logic [W:0] ref_mag(input logic [W-1:0] re, input logic [W-1:0] im);
    logic signed [W:0] sr;
    logic signed [W:0] si;
    logic [W:0]        ar;
    logic [W:0]        ai;
    sr = $signed({re[W-1], re});
    si = $signed({im[W-1], im});
    ar = (sr < 0) ? W'(0) - sr : sr;
    ai = (si < 0) ? W'(0) - si : si;
    return ar + (ai >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- instance A: MAG_LAT=1, BURST=2 ----------------
  logic         a_rst, a_v0, a_v1, a_rdy0, a_rdy1;
  logic [W-1:0] a_re0, a_im0, a_re1, a_im1;
  logic         a_mu_ena, a_mu_val, a_res0_val, a_res1_val, a_err, inj;
  logic [W-1:0] a_mu_real, a_mu_imag;
  logic [W:0]   a_mu_mag, a_res0_mag, a_res1_mag;
  logic [W+1:0] pa;

  mag_share_arb #(.WIDTH(W), .MAG_LAT(1), .BURST(2)) dut_a (
    .clk(clk), .rst(a_rst),
    .req0_val(a_v0), .req0_real(a_re0), .req0_imag(a_im0), .req0_rdy(a_rdy0),
    .req1_val(a_v1), .req1_real(a_re1), .req1_imag(a_im1), .req1_rdy(a_rdy1),
    .mu_ena(a_mu_ena), .mu_real(a_mu_real), .mu_imag(a_mu_imag),
    .mu_mag(a_mu_mag), .mu_val(a_mu_val),
    .res0_val(a_res0_val), .res0_mag(a_res0_mag),
    .res1_val(a_res1_val), .res1_mag(a_res1_mag), .err(a_err)
  );

  always @(posedge clk or negedge a_rst) begin
    if (!a_rst) pa <= '0;
    else        pa <= {a_mu_ena, ref_mag(a_mu_real, a_mu_imag)};
  end
  assign a_mu_val = pa[W+1] | inj;
  assign a_mu_mag = pa[W:0];

  // ---------------- instance B: MAG_LAT=3, BURST=2 ----------------
  logic         b_rst, b_v0, b_v1, b_rdy0, b_rdy1;
  logic [W-1:0] b_re0, b_im0, b_re1, b_im1;
  logic         b_mu_ena, b_mu_val, b_res0_val, b_res1_val, b_err;
  logic [W-1:0] b_mu_real, b_mu_imag;
  logic [W:0]   b_mu_mag, b_res0_mag, b_res1_mag;
  logic [W+1:0] pb [3];

  mag_share_arb #(.WIDTH(W), .MAG_LAT(3), .BURST(2)) dut_b (
    .clk(clk), .rst(b_rst),
    .req0_val(b_v0), .req0_real(b_re0), .req0_imag(b_im0), .req0_rdy(b_rdy0),
    .req1_val(b_v1), .req1_real(b_re1), .req1_imag(b_im1), .req1_rdy(b_rdy1),
    .mu_ena(b_mu_ena), .mu_real(b_mu_real), .mu_imag(b_mu_imag),
    .mu_mag(b_mu_mag), .mu_val(b_mu_val),
    .res0_val(b_res0_val), .res0_mag(b_res0_mag),
    .res1_val(b_res1_val), .res1_mag(b_res1_mag), .err(b_err)
  );

  always @(posedge clk or negedge b_rst) begin
    if (!b_rst) begin
      pb[0] <= '0;
      pb[1] <= '0;
      pb[2] <= '0;
    end else begin
      pb[0] <= {b_mu_ena, ref_mag(b_mu_real, b_mu_imag)};
      pb[1] <= pb[0];
      pb[2] <= pb[1];
    end
  end
  assign b_mu_val = pb[2][W+1];
  assign b_mu_mag = pb[2][W:0];

  // In-flight expectations die with the reset that kills the samples.
  always @(negedge a_rst) begin
    sb_a0.delete();
    sb_a1.delete();
  end
  always @(negedge b_rst) begin
    sb_b0.delete();
    sb_b1.delete();
  end

  // ---------------- scoreboard push (accepts) and pop (results) ----------------
  always @(negedge clk) begin : mon
    exp_t e;
    if (a_rst === 1'b1) begin
      if (a_v0 && a_rdy0) begin e.mag = ref_mag(a_re0, a_im0); e.due = 32'(cyc + 3); sb_a0.push_back(e); end
      if (a_v1 && a_rdy1) begin e.mag = ref_mag(a_re1, a_im1); e.due = 32'(cyc + 3); sb_a1.push_back(e); end
    end
    if (b_rst === 1'b1) begin
      if (b_v0 && b_rdy0) begin e.mag = ref_mag(b_re0, b_im0); e.due = 32'(cyc + 5); sb_b0.push_back(e); end
      if (b_v1 && b_rdy1) begin e.mag = ref_mag(b_re1, b_im1); e.due = 32'(cyc + 5); sb_b1.push_back(e); end
    end
    if (a_res0_val === 1'b1) begin
      if (sb_a0.size() == 0) chk("a_res0_unexpected", 32'(a_res0_val), 32'd0);
      else begin e = sb_a0.pop_front(); chk("a_res0_mag", 32'(a_res0_mag), 32'(e.mag)); chk("a_res0_lat", 32'(cyc), e.due); end
    end
    if (a_res1_val === 1'b1) begin
      if (sb_a1.size() == 0) chk("a_res1_unexpected", 32'(a_res1_val), 32'd0);
      else begin e = sb_a1.pop_front(); chk("a_res1_mag", 32'(a_res1_mag), 32'(e.mag)); chk("a_res1_lat", 32'(cyc), e.due); end
    end
    if (b_res0_val === 1'b1) begin
      if (sb_b0.size() == 0) chk("b_res0_unexpected", 32'(b_res0_val), 32'd0);
      else begin e = sb_b0.pop_front(); chk("b_res0_mag", 32'(b_res0_mag), 32'(e.mag)); chk("b_res0_lat", 32'(cyc), e.due); end
    end
    if (b_res1_val === 1'b1) begin
      if (sb_b1.size() == 0) chk("b_res1_unexpected", 32'(b_res1_val), 32'd0);
      else begin e = sb_b1.pop_front(); chk("b_res1_mag", 32'(b_res1_mag), 32'(e.mag)); chk("b_res1_lat", 32'(cyc), e.due); end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int k0;
    int k1;
    logic [7:0] exp_seq;
    a_rst = 1'b0; b_rst = 1'b0; inj = 1'b0;
    a_v0 = 1'b0; a_v1 = 1'b0; a_re0 = '0; a_im0 = '0; a_re1 = '0; a_im1 = '0;
    b_v0 = 1'b0; b_v1 = 1'b0; b_re0 = '0; b_im0 = '0; b_re1 = '0; b_im1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mu_ena",   32'(a_mu_ena),   32'd0);
    chk("rst_res0_val", 32'(a_res0_val), 32'd0);
    chk("rst_res0_mag", 32'(a_res0_mag), 32'd0);
    chk("rst_err",      32'(a_err),      32'd0);
    a_rst = 1'b1; b_rst = 1'b1;

    // 1: port 0 alone, (3,-4) -> 5
    @(posedge clk); #1; a_v0 = 1'b1; a_re0 = 16'd3; a_im0 = 16'hfffc;
    @(negedge clk); chk("t1_rdy0", 32'(a_rdy0), 32'd1); chk("t1_rdy1", 32'(a_rdy1), 32'd0);
    @(posedge clk); #1; a_v0 = 1'b0;
    @(negedge clk);
    chk("t1_mu_ena", 32'(a_mu_ena), 32'd1);
    chk("t1_mu_real", 32'(a_mu_real), 32'h0003);
    chk("t1_mu_imag", 32'(a_mu_imag), 32'hfffc);
    @(negedge clk); chk("t1_res0_early", 32'(a_res0_val), 32'd0);
    @(negedge clk);
    chk("t1_res0_val", 32'(a_res0_val), 32'd1);
    chk("t1_res0_mag", 32'(a_res0_mag), 32'd5);
    chk("t1_res1_val", 32'(a_res1_val), 32'd0);

    // 2: port 1 alone, (-8,2) -> 9
    @(posedge clk); #1; a_v1 = 1'b1; a_re1 = 16'hfff8; a_im1 = 16'd2;
    @(negedge clk); chk("t2_rdy1", 32'(a_rdy1), 32'd1);
    @(posedge clk); #1; a_v1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t2_res1_val", 32'(a_res1_val), 32'd1);
    chk("t2_res1_mag", 32'(a_res1_mag), 32'd9);
    chk("t2_res0_val", 32'(a_res0_val), 32'd0);
    chk("t2_err", 32'(a_err), 32'd0);

    // 3: sustained contention from a fresh owner state
    @(posedge clk); #1; a_rst = 1'b0;
    @(posedge clk); #1; a_rst = 1'b1;
    k0 = 0; k1 = 0;
    exp_seq = 8'b1100_1100;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      a_v0 = 1'b1; a_re0 = W'(k0 + 1);      a_im0 = W'(-(k0 + 2));
      a_v1 = 1'b1; a_re1 = W'(-(k1 + 10));  a_im1 = W'(k1 + 3);
      @(negedge clk);
      chk($sformatf("t3_gnt1_%0d", k), 32'(a_rdy1), 32'(exp_seq[k]));
      chk($sformatf("t3_gnt0_%0d", k), 32'(a_rdy0), 32'(!exp_seq[k]));
      if (a_rdy0) k0++;
      if (a_rdy1) k1++;
    end
    @(posedge clk); #1; a_v0 = 1'b0; a_v1 = 1'b0;
    repeat (5) @(negedge clk);
    chk("t3_err", 32'(a_err), 32'd0);

    // 4: spurious mu_val with empty tag pipe
    @(posedge clk); #1; inj = 1'b1;
    @(posedge clk); #1; inj = 1'b0;
    @(negedge clk); chk("t4_err_set", 32'(a_err), 32'd1);
    repeat (5) @(negedge clk);
    chk("t4_err_sticky", 32'(a_err), 32'd1);

    // 5: async reset with two samples in flight
    @(posedge clk); #1; a_v0 = 1'b1; a_re0 = 16'd100; a_im0 = 16'd50;
    @(negedge clk); chk("t5_rdy_a", 32'(a_rdy0), 32'd1);
    @(posedge clk); #1; a_re0 = 16'hfff9; a_im0 = 16'd7;
    @(negedge clk); chk("t5_rdy_b", 32'(a_rdy0), 32'd1);
    @(posedge clk); #1; a_v0 = 1'b0;
    #2; a_rst = 1'b0;
    #1;
    chk("t5_mu_ena",   32'(a_mu_ena),   32'd0);
    chk("t5_mu_real",  32'(a_mu_real),  32'd0);
    chk("t5_mu_imag",  32'(a_mu_imag),  32'd0);
    chk("t5_res0_val", 32'(a_res0_val), 32'd0);
    chk("t5_res1_val", 32'(a_res1_val), 32'd0);
    chk("t5_res0_mag", 32'(a_res0_mag), 32'd0);
    chk("t5_res1_mag", 32'(a_res1_mag), 32'd0);
    chk("t5_err",      32'(a_err),      32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); a_rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("t5_err_after", 32'(a_err), 32'd0);
    @(posedge clk); #1;
    a_v0 = 1'b1; a_re0 = 16'd6;  a_im0 = 16'd6;
    a_v1 = 1'b1; a_re1 = 16'd11; a_im1 = 16'hfff5;
    @(negedge clk); chk("t5_owner0_rdy0", 32'(a_rdy0), 32'd1); chk("t5_owner0_rdy1", 32'(a_rdy1), 32'd0);
    @(posedge clk); #1; a_v0 = 1'b0;
    @(negedge clk); chk("t5_rdy1", 32'(a_rdy1), 32'd1);
    @(posedge clk); #1; a_v1 = 1'b0;
    repeat (6) @(negedge clk);

    // 6: MAG_LAT=3 instance, alternating single requests
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      b_v0 = (k % 2 == 0); b_re0 = W'(20 + k);     b_im0 = W'(-(3 * k));
      b_v1 = (k % 2 != 0); b_re1 = W'(-(5 + k));   b_im1 = W'(7 * k);
      @(negedge clk);
      chk($sformatf("t6_rdy_%0d", k), 32'(b_v0 ? b_rdy0 : b_rdy1), 32'd1);
    end
    @(posedge clk); #1; b_v0 = 1'b0; b_v1 = 1'b0;
    repeat (8) @(negedge clk);
    chk("t6_err", 32'(b_err), 32'd0);

    chk("sb_a0_empty", 32'(sb_a0.size()), 32'd0);
    chk("sb_a1_empty", 32'(sb_a1.size()), 32'd0);
    chk("sb_b0_empty", 32'(sb_b0.size()), 32'd0);
    chk("sb_b1_empty", 32'(sb_b1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
